// File: rtl/sender_sched.sv
`timescale 1ns/1ps
// sender_sched: scheduled GMII transmit engine.
// Fetches frame records from the TX slot RAM, drops records with a bad magic
// or illegal length, waits until global_counter reaches the record timestamp,
// then sends preamble/SFD, payload, zero padding up to MIN_LEN, FCS and IFG.
//
// Ports:
//   gmii_tx_clk       sole clock (125 MHz)
//   sys_rst_n         asynchronous active-low reset
//   global_counter    64-bit time base compared against record timestamps
//   enable            allows new frames to start (sampled in IDLE only)
//   gmii_txd/_tx_en   GMII transmit data / enable (registered)
//   slot_tx_eth_addr  slot RAM read address (mirrors mem_rd_ptr)
//   slot_tx_eth_q     slot RAM read data, one-cycle latency
//   mem_wr_ptr        writer pointer (whole records only)
//   mem_rd_ptr        reader pointer, word granular
//   busy              high whenever not IDLE
//   tx_frame_count    frames sent (wraps)
//   tx_drop_count     records dropped (saturates)
module sender_sched #(
  parameter int unsigned ADDR_W  = 14,
  parameter logic [15:0] MAGIC   = 16'h5555,
  parameter int unsigned MAX_LEN = 1514,
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned IFG_LEN = 12
) (
  input  logic              gmii_tx_clk,
  input  logic              sys_rst_n,
  input  logic [63:0]       global_counter,
  input  logic              enable,
  output logic [7:0]        gmii_txd,
  output logic              gmii_tx_en,
  output logic [ADDR_W-1:0] slot_tx_eth_addr,
  input  logic [15:0]       slot_tx_eth_q,
  input  logic [ADDR_W-1:0] mem_wr_ptr,
  output logic [ADDR_W-1:0] mem_rd_ptr,
  output logic              busy,
  output logic [31:0]       tx_frame_count,
  output logic [15:0]       tx_drop_count
);

  localparam logic [15:0]       MAX_W   = 16'(MAX_LEN);
  localparam logic [15:0]       MIN_W   = 16'(MIN_LEN);
  localparam logic [15:0]       IFG_W   = 16'(IFG_LEN);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_WAIT_TS, S_PREAMBLE, S_DATA, S_PAD, S_FCS, S_IFG, S_DROP
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       crc_q, crc_d;
  logic [7:0]        txd_q, txd_d;
  logic              txen_q, txen_d;
  logic [31:0]       frame_q, frame_d;
  logic [15:0]       drop_q, drop_d;
  logic [15:0]       magic_q, len_q;
  logic [63:0]       ts_q;
  logic              hdr_bad;
  logic [7:0]        data_byte;
  logic [31:0]       fcs_sh;

  // Reflected IEEE 802.3 CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB8_8320;
    end
    return r;
  endfunction

  assign hdr_bad   = (magic_q != MAGIC) || (len_q == '0) || (len_q > MAX_W);
  assign data_byte = cnt_q[0] ? slot_tx_eth_q[7:0] : slot_tx_eth_q[15:8];
  assign fcs_sh    = (~crc_q) >> {cnt_q[1:0], 3'b000};

  // The read pointer is bumped when the high byte of a word goes out; the RAM
  // still presents that word during the following (low byte) cycle, and the
  // next word is ready one cycle later, so DATA streams without gaps.
  // The pointer steps ahead of the RAM latency during HDR so it rests on the
  // first payload word when the header check is made.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    crc_d   = crc_q;
    txd_d   = '0;
    txen_d  = 1'b0;
    frame_d = frame_q;
    drop_d  = drop_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable && (ptr_q != mem_wr_ptr)) begin
          state_d = S_HDR;
          ptr_d   = ptr_q + PTR_ONE;
        end
      end
      S_HDR: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q < 16'd7) ptr_d = ptr_q + PTR_ONE;
        if (cnt_q == 16'd8) begin
          cnt_d   = '0;
          state_d = hdr_bad ? S_DROP : S_WAIT_TS;
        end
      end
      S_WAIT_TS: begin
        crc_d = '1;
        if (global_counter >= ts_q) begin
          txen_d  = 1'b1;
          txd_d   = 8'h55;
          cnt_d   = 16'd1;
          state_d = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        txen_d = 1'b1;
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == 16'd7) begin
          txd_d   = 8'hD5;
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          txd_d = 8'h55;
        end
      end
      S_DATA: begin
        txen_d = 1'b1;
        txd_d  = data_byte;
        crc_d  = crc_byte(crc_q, data_byte);
        cnt_d  = cnt_q + 16'd1;
        if (!cnt_q[0]) ptr_d = ptr_q + PTR_ONE;
        if (cnt_q + 16'd1 == len_q) begin
          if (cnt_q + 16'd1 < MIN_W) begin
            state_d = S_PAD;
          end else begin
            cnt_d   = '0;
            state_d = S_FCS;
          end
        end
      end
      S_PAD: begin
        txen_d = 1'b1;
        txd_d  = 8'h00;
        crc_d  = crc_byte(crc_q, 8'h00);
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q + 16'd1 == MIN_W) begin
          cnt_d   = '0;
          state_d = S_FCS;
        end
      end
      S_FCS: begin
        txen_d = 1'b1;
        txd_d  = fcs_sh[7:0];
        cnt_d  = cnt_q + 16'd1;
        if (cnt_q == 16'd3) begin
          cnt_d   = '0;
          frame_d = frame_q + 32'd1;
          state_d = S_IFG;
        end
      end
      // One extra cycle here: the last FCS byte is still on the bus during the
      // first IFG cycle because the GMII outputs are registered.
      S_IFG: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == IFG_W) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        ptr_d   = mem_wr_ptr;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      crc_q   <= '1;
      txd_q   <= '0;
      txen_q  <= 1'b0;
      frame_q <= '0;
      drop_q  <= '0;
      magic_q <= '0;
      len_q   <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      crc_q   <= crc_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
      if (state_q == S_HDR) begin
        unique case (cnt_q)
          16'd0:                      magic_q <= slot_tx_eth_q;
          16'd1:                      len_q   <= slot_tx_eth_q;
          16'd2, 16'd3, 16'd4, 16'd5: ts_q    <= {ts_q[47:0], slot_tx_eth_q};
          default: ;
        endcase
      end
    end
  end

  assign gmii_txd         = txd_q;
  assign gmii_tx_en       = txen_q;
  assign mem_rd_ptr       = ptr_q;
  assign slot_tx_eth_addr = ptr_q;
  assign busy             = (state_q != S_IDLE);
  assign tx_frame_count   = frame_q;
  assign tx_drop_count    = drop_q;

endmodule

// File: tb/tb_sender_sched.sv
`timescale 1ns/1ps
module tb_sender_sched;
  localparam int unsigned IFG_LEN = 12;
  localparam int unsigned MIN_LEN = 60;
  localparam logic [15:0] MAGIC   = 16'h5555;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] tick = '0;
  logic [63:0] off;
  logic [63:0] gc;
  logic        enable;
  logic [7:0]  txd;
  logic        tx_en;
  logic [13:0] addr;
  logic [15:0] q;
  logic [13:0] wr_ptr;
  logic [13:0] rd_ptr;
  logic        busy;
  logic [31:0] fcnt;
  logic [15:0] dcnt;

  logic [15:0] mem [0:16383];
  logic [31:0] crc_tbl [0:255];
  logic [7:0]  exp_q [$];

  logic [13:0] exp_rd;
  logic [31:0] exp_fc;
  logic [15:0] exp_dc;

  int unsigned vectors;
  int unsigned miscompares;

  always #4 clk = ~clk;
  always @(posedge clk) tick <= tick + 64'd1;
  always @(posedge clk) q <= mem[addr];
  assign gc = tick + off;

  sender_sched #(
    .ADDR_W (14),
    .MAGIC  (16'h5555),
    .MAX_LEN(1514),
    .MIN_LEN(60),
    .IFG_LEN(12)
  ) dut (
    .gmii_tx_clk     (clk),
    .sys_rst_n       (rst_n),
    .global_counter  (gc),
    .enable          (enable),
    .gmii_txd        (txd),
    .gmii_tx_en      (tx_en),
    .slot_tx_eth_addr(addr),
    .slot_tx_eth_q   (q),
    .mem_wr_ptr      (wr_ptr),
    .mem_rd_ptr      (rd_ptr),
    .busy            (busy),
    .tx_frame_count  (fcnt),
    .tx_drop_count   (dcnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write one record (header + random payload) into the slot RAM model.
  task automatic put_record(input logic [13:0] start, input logic [15:0] magic,
                            input logic [15:0] len, input logic [63:0] ts,
                            output logic [13:0] next);
    int unsigned nw;
    mem[start] = magic;
    mem[14'(start + 1)] = len;
    for (int unsigned k = 0; k < 4; k++) mem[14'(start + 2 + k)] = ts[63 - 16*k -: 16];
    mem[14'(start + 6)] = 16'(($urandom));
    mem[14'(start + 7)] = 16'(($urandom));
    nw = (int'(len) + 1) / 2;
    for (int unsigned k = 0; k < nw; k++) mem[14'(start + 8 + k)] = 16'($urandom);
    next = 14'(start + 8 + nw);
  endtask

  // Expected wire bytes of a legal record: preamble, payload, pad, FCS.
  task automatic build_expect(input logic [13:0] start, output logic [13:0] next);
    logic [15:0]  len;
    logic [15:0]  w;
    logic [31:0]  c;
    logic [7:0]   b;
    logic [7:0]   idx;
    int unsigned  total;
    exp_q.delete();
    len = mem[14'(start + 1)];
    for (int unsigned k = 0; k < 7; k++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    total = (int'(len) < MIN_LEN) ? MIN_LEN : int'(len);
    c = 32'hFFFF_FFFF;
    for (int unsigned i = 0; i < total; i++) begin
      if (i < len) begin
        w = mem[14'(start + 8 + i / 2)];
        b = (i % 2 == 0) ? w[15:8] : w[7:0];
      end else begin
        b = 8'h00;
      end
      exp_q.push_back(b);
      idx = c[7:0] ^ b;
      c = crc_tbl[idx] ^ (c >> 8);
    end
    c = ~c;
    for (int unsigned k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    next = 14'(start + 8 + (int'(len) + 1) / 2);
  endtask

  task automatic run_frame(input string tag, input logic [13:0] start,
                           input logic [63:0] ts, input bit kill_en);
    logic [7:0]  got [$];
    logic [13:0] nxt;
    logic [63:0] g0;
    logic [63:0] exp_start;
    bit          ok;
    bit          txd_dirty;
    int unsigned ifg;
    build_expect(start, nxt);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) begin ok = 1; break; end
    end
    check_eq({tag, "_busy"}, 64'(ok), 64'd1);
    if (!ok) return;
    g0 = gc;
    ok = 0;
    txd_dirty = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tx_en) begin ok = 1; break; end
      if (txd != 8'h00) txd_dirty = 1;
    end
    check_eq({tag, "_txen"}, 64'(ok), 64'd1);
    if (!ok) return;
    exp_start = (g0 + 64'd10 > ts + 64'd1) ? g0 + 64'd10 : ts + 64'd1;
    check_eq({tag, "_start"}, gc, exp_start);
    if (kill_en) enable = 1'b0;
    for (int i = 0; i < 3100 && tx_en; i++) begin
      got.push_back(txd);
      @(negedge clk);
    end
    ifg = 0;
    for (int i = 0; i < 1000 && busy; i++) begin
      if (tx_en || txd != 8'h00) txd_dirty = 1;
      ifg++;
      @(negedge clk);
    end
    check_eq({tag, "_ifg"}, 64'(ifg), 64'(IFG_LEN));
    check_eq({tag, "_idle_txd"}, 64'(txd_dirty), 64'd0);
    check_eq({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check_eq($sformatf("%s_b%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    exp_rd = nxt;
    exp_fc = exp_fc + 32'd1;
    check_eq({tag, "_rdptr"}, 64'(rd_ptr), 64'(exp_rd));
    check_eq({tag, "_fcnt"}, 64'(fcnt), 64'(exp_fc));
  endtask

  task automatic run_drop(input string tag, input logic [13:0] exp_ptr);
    bit ok;
    bit seen_tx;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) begin ok = 1; break; end
    end
    check_eq({tag, "_busy"}, 64'(ok), 64'd1);
    seen_tx = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      if (tx_en) seen_tx = 1;
      @(negedge clk);
    end
    if (exp_dc != 16'hFFFF) exp_dc = exp_dc + 16'd1;
    exp_rd = exp_ptr;
    check_eq({tag, "_notx"}, 64'(seen_tx), 64'd0);
    check_eq({tag, "_rdptr"}, 64'(rd_ptr), 64'(exp_rd));
    check_eq({tag, "_dcnt"}, 64'(dcnt), 64'(exp_dc));
    check_eq({tag, "_fcnt"}, 64'(fcnt), 64'(exp_fc));
  endtask

  initial begin
    logic [13:0] n1;
    logic [13:0] n2;
    logic [31:0] c;
    logic [15:0] rlen;
    logic [63:0] rts;
    bit          ok;
    bit          busy_seen;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    wr_ptr = '0;
    off = '0;
    exp_rd = '0;
    exp_fc = '0;
    exp_dc = '0;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tbl[n] = c;
    end

    repeat (3) @(negedge clk);
    check_eq("rst_txen", 64'(tx_en), 64'd0);
    check_eq("rst_txd", 64'(txd), 64'd0);
    check_eq("rst_rdptr", 64'(rd_ptr), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_fcnt", 64'(fcnt), 64'd0);
    check_eq("rst_dcnt", 64'(dcnt), 64'd0);
    rst_n = 1'b1;
    enable = 1'b1;

    // 64-byte frame at pointer 0
    put_record(14'd0, MAGIC, 16'd64, 64'd0, n1);
    wr_ptr = n1;
    run_frame("t1", exp_rd, 64'd0, 0);
    check_eq("t1_ptr40", 64'(rd_ptr), 64'd40);

    // odd short frame padded, followed by a second record right behind it
    put_record(exp_rd, MAGIC, 16'd17, 64'd0, n1);
    put_record(n1, MAGIC, 16'd30, 64'd0, n2);
    wr_ptr = n2;
    run_frame("t2a", exp_rd, 64'd0, 0);
    run_frame("t2b", exp_rd, 64'd0, 0);

    // scheduled launch: future timestamp, then one already past
    off = 64'd200 - tick;
    put_record(exp_rd, MAGIC, 16'd20, 64'd1000, n1);
    put_record(n1, MAGIC, 16'd25, 64'd150, n2);
    wr_ptr = n2;
    run_frame("t3a", exp_rd, 64'd1000, 0);
    run_frame("t3b", exp_rd, 64'd150, 0);

    // drops: bad magic, over-long, zero length; last one reseeks to the wrap edge
    put_record(exp_rd, 16'h1234, 16'd20, 64'd0, n1);
    wr_ptr = 14'd300;
    run_drop("t4magic", 14'd300);
    put_record(exp_rd, MAGIC, 16'd1515, 64'd0, n1);
    wr_ptr = n1;
    run_drop("t4long", n1);
    put_record(exp_rd, MAGIC, 16'd0, 64'd0, n1);
    wr_ptr = n1;
    run_drop("t4zero", n1);
    put_record(exp_rd, 16'hAAAA, 16'd4, 64'd0, n1);
    wr_ptr = 14'd16381;
    run_drop("t4seek", 14'd16381);

    // record straddling the pointer wrap
    put_record(exp_rd, MAGIC, 16'd10, 64'd0, n1);
    wr_ptr = n1;
    run_frame("t5wrap", exp_rd, 64'd0, 0);
    check_eq("t5_ptr10", 64'(rd_ptr), 64'd10);

    // length boundaries around MIN_LEN and MAX_LEN
    put_record(exp_rd, MAGIC, 16'd59, 64'd0, n1);
    put_record(n1, MAGIC, 16'd60, 64'd0, n2);
    put_record(n2, MAGIC, 16'd1, 64'd0, n1);
    put_record(n1, MAGIC, 16'd1514, 64'd0, n2);
    wr_ptr = n2;
    run_frame("b59", exp_rd, 64'd0, 0);
    run_frame("b60", exp_rd, 64'd0, 0);
    run_frame("b1", exp_rd, 64'd0, 0);
    run_frame("b1514", exp_rd, 64'd0, 0);

    // randomized frames with random lengths and near-future timestamps
    for (int r = 0; r < 8; r++) begin
      rlen = 16'($urandom_range(1, 150));
      rts = ($urandom_range(0, 1) == 1) ? gc + 64'($urandom_range(0, 60)) : 64'd0;
      put_record(exp_rd, MAGIC, rlen, rts, n1);
      wr_ptr = n1;
      run_frame($sformatf("rnd%0d", r), exp_rd, rts, 0);
    end

    // reset during payload byte 20
    put_record(exp_rd, MAGIC, 16'd64, 64'd0, n1);
    wr_ptr = n1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_en) begin ok = 1; break; end
    end
    check_eq("t6_txen", 64'(ok), 64'd1);
    repeat (28) @(negedge clk);
    check_eq("t6_midframe", 64'(tx_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_txen", 64'(tx_en), 64'd0);
    check_eq("t6_rst_txd", 64'(txd), 64'd0);
    check_eq("t6_rst_busy", 64'(busy), 64'd0);
    check_eq("t6_rst_rdptr", 64'(rd_ptr), 64'd0);
    check_eq("t6_rst_fcnt", 64'(fcnt), 64'd0);
    check_eq("t6_rst_dcnt", 64'(dcnt), 64'd0);
    wr_ptr = '0;
    exp_rd = '0;
    exp_fc = '0;
    exp_dc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    put_record(14'd0, MAGIC, 16'd40, 64'd0, n1);
    wr_ptr = n1;
    run_frame("t6post", exp_rd, 64'd0, 0);

    // enable dropped mid-frame: frame finishes, next queued frame waits
    put_record(exp_rd, MAGIC, 16'd70, 64'd0, n1);
    put_record(n1, MAGIC, 16'd33, 64'd0, n2);
    wr_ptr = n2;
    run_frame("t6en", exp_rd, 64'd0, 1);
    busy_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy || tx_en) busy_seen = 1;
    end
    check_eq("t6en_parked", 64'(busy_seen), 64'd0);
    check_eq("t6en_rdptr", 64'(rd_ptr), 64'(n1));
    enable = 1'b1;
    run_frame("t6resume", exp_rd, 64'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
